// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the per-axis phase type.
// Used by vga_axis_counter and vga_timing_gen.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } axis_phase_e;

  function automatic axis_phase_e phase_of(input logic [CNT_W-1:0] count,
                                           input int active, input int fp, input int sync);
    int c;
    c = int'(count);
    if (c < active)                  return PH_ACTIVE;
    else if (c < active + fp)        return PH_FRONT;
    else if (c < active + fp + sync) return PH_SYNC;
    else                             return PH_BACK;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus the phase it is about to enter.
// phase decodes the value the counter takes on the coming edge so the parent can register it.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             wrap,
  output logic [CNT_W-1:0] count,
  output axis_phase_e      phase,
  output logic             wrap_out
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wrap_out = step && (wrap || count == LAST);
    count_d  = count;
    if (wrap_out)  count_d = '0;
    else if (step) count_d = count + 1'b1;
    phase = phase_of(count_d, ACTIVE, FP, SYNC);
  end

  // NOTE: reset parks the counter on its last position so the first step lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= LAST;
    else        count <= count_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered x/y, active-video, sync and frame-start outputs.
// Optional frame counter port enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE         = H_ACTIVE_DEF,
  parameter int H_FP             = H_FP_DEF,
  parameter int H_SYNC           = H_SYNC_DEF,
  parameter int H_BP             = H_BP_DEF,
  parameter int V_ACTIVE         = V_ACTIVE_DEF,
  parameter int V_FP             = V_FP_DEF,
  parameter int V_SYNC           = V_SYNC_DEF,
  parameter int V_BP             = V_BP_DEF,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_active,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  localparam logic SYNC_ON  = SYNC_ACTIVE_HIGH ? 1'b1 : 1'b0;
  localparam logic SYNC_OFF = ~SYNC_ON;

  axis_phase_e h_phase, v_phase;
  logic        h_wrap, v_wrap, frame_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step(pix_en), .wrap(1'b0),
    .count(x), .phase(h_phase), .wrap_out(h_wrap)
  );

  // The vertical axis only moves on the horizontal wrap, so y never changes mid-line.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step(h_wrap), .wrap(1'b0),
    .count(y), .phase(v_phase), .wrap_out(v_wrap)
  );

  assign frame_wrap = h_wrap && v_wrap;

  // Decodes come from the next-position phases, so these flops move on the same edge as x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync        <= SYNC_OFF;
      vsync        <= SYNC_OFF;
      frame_active <= 1'b0;
      frame_start  <= 1'b0;
    end else if (pix_en) begin
      hsync        <= (h_phase == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      vsync        <= (v_phase == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      frame_active <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      frame_start  <= frame_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          frame_cnt <= 8'hFF;
    else if (frame_wrap) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule
